// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-cycle data memory port: A has priority,
// B is guaranteed a grant after STARVE_LIMIT consecutive A grants while it waits.
//
// state | meaning
// IDLE  | no response due this cycle
// RESP  | response for last cycle's accept is due; owner_b_q/is_write_q describe it
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clock_mem,
  input  logic             rst,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [31:0]      a_addr,
  input  logic [31:0]      a_wdata,
  input  logic [3:0]       a_we,
  output logic             a_rsp_valid,
  output logic [31:0]      a_rdata,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [31:0]      b_addr,
  input  logic [31:0]      b_wdata,
  input  logic [3:0]       b_we,
  output logic             b_rsp_valid,
  output logic [31:0]      b_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_we,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] starve_cnt
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_b_q, owner_b_d;
  logic        is_write_q, is_write_d;
  logic        win_a, win_b, accept;
  logic        in_resp, rsp_a, rsp_b;
  logic [31:0] rsp_data;
  logic [31:0] a_rdata_q, b_rdata_q;

  always_comb begin
    win_b = !rst && b_req_valid && (!a_req_valid || (starve_cnt == LIMIT));
    win_a = !rst && a_req_valid && !win_b;
  end

  assign a_req_ready = win_a;
  assign b_req_ready = win_b;
  assign accept      = win_a | win_b;

  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 4'h0;
    if (win_b) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_we    = b_we;
    end else if (win_a) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_we    = a_we;
    end
  end

  always_comb begin
    state_d    = IDLE;
    owner_b_d  = owner_b_q;
    is_write_d = is_write_q;
    if (accept) begin
      state_d    = RESP;
      owner_b_d  = win_b;
      is_write_d = (mem_we != 4'h0);
    end
  end

  always_ff @(posedge clock_mem) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_b_q  <= 1'b0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_b_q  <= owner_b_d;
      is_write_q <= is_write_d;
    end
  end

  // Gating with rst drops a response that falls due while reset is asserted.
  assign in_resp  = (state_q == RESP) && !rst;
  assign rsp_a    = in_resp && !owner_b_q;
  assign rsp_b    = in_resp && owner_b_q;
  assign rsp_data = is_write_q ? 32'h0 : mem_rdata;

  assign a_rsp_valid = rsp_a;
  assign b_rsp_valid = rsp_b;
  assign a_rdata     = rsp_a ? rsp_data : a_rdata_q;
  assign b_rdata     = rsp_b ? rsp_data : b_rdata_q;

  always_ff @(posedge clock_mem) begin
    if (rst) begin
      a_rdata_q <= 32'h0;
      b_rdata_q <= 32'h0;
    end else begin
      if (rsp_a) a_rdata_q <= rsp_data;
      if (rsp_b) b_rdata_q <= rsp_data;
    end
  end

  always_ff @(posedge clock_mem) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (win_b || !b_req_valid) begin
      starve_cnt <= '0;
    end else if (win_a && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-cycle memory.
module tb_dmem_port_arbiter;

  logic        clock_mem = 1'b0;
  logic        rst = 1'b1;
  logic        a_req_valid = 1'b0, a_req_ready;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_we = '0;
  logic        a_rsp_valid;
  logic [31:0] a_rdata;
  logic        b_req_valid = 1'b0, b_req_ready;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_we = '0;
  logic        b_rsp_valid;
  logic [31:0] b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [3:0]  starve_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock_mem = ~clock_mem;

  dmem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clock_mem(clock_mem), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_we(a_we), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_we(b_we), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  logic [31:0] mem [0:255];
  logic [31:0] mem_rd_q = '0;
  assign mem_rdata = mem_rd_q;

  always @(posedge clock_mem) begin
    for (int k = 0; k < 4; k++)
      if (mem_we[k]) mem[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rd_q <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic rst; logic av; logic [31:0] aa; logic [31:0] aw; logic [3:0] awe;
    logic bv; logic [31:0] ba; logic [31:0] bw; logic [3:0] bwe;
    logic ar; logic br; logic [3:0] mwe; logic [31:0] maddr; logic [31:0] mwdata;
    logic ars; logic [31:0] ard; logic brs; logic [31:0] brd; logic [3:0] cnt;
  } vec_t;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] A10 = 32'h10;
  localparam logic [31:0] A20 = 32'h20;
  localparam logic [31:0] A30 = 32'h30;
  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] P   = 32'h12345678;
  localparam logic [31:0] BW  = 32'h0000AB00;
  localparam logic [31:0] BM  = 32'h1122AB44;
  localparam logic [3:0]  W0 = 4'h0, WF = 4'hF, W2 = 4'h2;
  localparam logic [3:0]  C0 = 4'd0, C1 = 4'd1, C2 = 4'd2, C3 = 4'd3, C4 = 4'd4;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    a_req_valid = v.av; a_addr = v.aa; a_wdata = v.aw; a_we = v.awe;
    b_req_valid = v.bv; b_addr = v.ba; b_wdata = v.bw; b_we = v.bwe;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d a_req_ready", i), {31'h0, a_req_ready}, {31'h0, v.ar});
    chk($sformatf("v%0d b_req_ready", i), {31'h0, b_req_ready}, {31'h0, v.br});
    chk($sformatf("v%0d mem_we", i), {28'h0, mem_we}, {28'h0, v.mwe});
    chk($sformatf("v%0d mem_addr", i), mem_addr, v.maddr);
    chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.mwdata);
    chk($sformatf("v%0d a_rsp_valid", i), {31'h0, a_rsp_valid}, {31'h0, v.ars});
    chk($sformatf("v%0d a_rdata", i), a_rdata, v.ard);
    chk($sformatf("v%0d b_rsp_valid", i), {31'h0, b_rsp_valid}, {31'h0, v.brs});
    chk($sformatf("v%0d b_rdata", i), b_rdata, v.brd);
    chk($sformatf("v%0d starve_cnt", i), {28'h0, starve_cnt}, {28'h0, v.cnt});
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[8]  = P;
    mem[12] = 32'h11223344;

    // reset with A requesting, then A write/read of 0x10
    vecs[0]  = '{I,I,A10,Z,W0,   O,Z,Z,W0,     O,O,W0,Z,Z,      O,Z,O,Z,C0};
    vecs[1]  = '{I,I,A10,Z,W0,   O,Z,Z,W0,     O,O,W0,Z,Z,      O,Z,O,Z,C0};
    vecs[2]  = '{O,I,A10,DB,WF,  O,Z,Z,W0,     I,O,WF,A10,DB,   O,Z,O,Z,C0};
    vecs[3]  = '{O,I,A10,Z,W0,   O,Z,Z,W0,     I,O,W0,A10,Z,    I,Z,O,Z,C0};
    vecs[4]  = '{O,O,Z,Z,W0,     O,Z,Z,W0,     O,O,W0,Z,Z,      I,DB,O,Z,C0};
    vecs[5]  = '{O,O,Z,Z,W0,     O,Z,Z,W0,     O,O,W0,Z,Z,      O,DB,O,Z,C0};
    // B alone: read 0x20, byte write to 0x30, read back
    vecs[6]  = '{O,O,Z,Z,W0,     I,A20,Z,W0,   O,I,W0,A20,Z,    O,DB,O,Z,C0};
    vecs[7]  = '{O,O,Z,Z,W0,     O,Z,Z,W0,     O,O,W0,Z,Z,      O,DB,I,P,C0};
    vecs[8]  = '{O,O,Z,Z,W0,     I,A30,BW,W2,  O,I,W2,A30,BW,   O,DB,O,P,C0};
    vecs[9]  = '{O,O,Z,Z,W0,     I,A30,Z,W0,   O,I,W0,A30,Z,    O,DB,I,Z,C0};
    vecs[10] = '{O,O,Z,Z,W0,     O,Z,Z,W0,     O,O,W0,Z,Z,      O,DB,I,BM,C0};
    // both valid: A,A,A,A,B,A,A,A,A,B
    vecs[11] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    O,DB,O,BM,C0};
    vecs[12] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    I,DB,O,BM,C1};
    vecs[13] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    I,DB,O,BM,C2};
    vecs[14] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    I,DB,O,BM,C3};
    vecs[15] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   O,I,W0,A20,Z,    I,DB,O,BM,C4};
    vecs[16] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    O,DB,I,P,C0};
    vecs[17] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    I,DB,O,P,C1};
    vecs[18] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    I,DB,O,P,C2};
    vecs[19] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   I,O,W0,A10,Z,    I,DB,O,P,C3};
    vecs[20] = '{O,I,A10,Z,W0,   I,A20,Z,W0,   O,I,W0,A20,Z,    I,DB,O,P,C4};
    vecs[21] = '{O,I,A10,Z,W0,   O,Z,Z,W0,     I,O,W0,A10,Z,    O,DB,I,P,C0};
    vecs[22] = '{O,O,Z,Z,W0,     O,Z,Z,W0,     O,O,W0,Z,Z,      I,DB,O,P,C0};

    for (int i = 0; i < 23; i++) begin
      @(posedge clock_mem); #1;
      drive(vecs[i]);
      @(negedge clock_mem);
      check_vec(i, vecs[i]);
    end

    // reset while an A read response is due; counter built up beforehand
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_mem); #1;
      rst = 1'b0;
      a_req_valid = 1'b1; a_addr = A10; a_wdata = Z; a_we = W0;
      b_req_valid = 1'b1; b_addr = A20; b_wdata = Z; b_we = W0;
      @(negedge clock_mem);
      chk($sformatf("pre_rst%0d a_req_ready", i), {31'h0, a_req_ready}, 32'h1);
      chk($sformatf("pre_rst%0d starve_cnt", i), {28'h0, starve_cnt}, i);
    end
    @(posedge clock_mem); #1;
    rst = 1'b1; a_req_valid = 1'b0; b_req_valid = 1'b0;
    @(negedge clock_mem);
    chk("mid_rst a_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    chk("mid_rst starve_cnt", {28'h0, starve_cnt}, 32'h3);
    @(posedge clock_mem); #1;
    rst = 1'b0;
    @(negedge clock_mem);
    chk("post_rst a_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    chk("post_rst starve_cnt", {28'h0, starve_cnt}, 32'h0);
    chk("post_rst a_rdata", a_rdata, 32'h0);
    chk("post_rst b_rdata", b_rdata, 32'h0);
    @(posedge clock_mem); #1;
    @(negedge clock_mem);
    chk("post_rst2 a_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data port of the single-cycle memory between two requesters.
- Port A is the multicycle datapath (high priority). Port B is a debug/program-loader master (low priority, starvation-protected).
- Sits between the requesters and the memory's addr/store-data/byte-enable/load-data pins, all in the clock_mem domain.
- Does valid/ready acceptance, fixed priority with bounded starvation, and routes the 1-cycle-later response back to the winning requester.

Parameters:
- STARVE_LIMIT, 4: max consecutive A grants while B is valid and waiting; the next grant goes to B. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clock_mem  in  1  memory clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req_valid  in  1  A request present.
- a_req_ready  out  1  A request accepted this cycle (combinational).
- a_addr  in  32  A byte address; word-aligned use only.
- a_wdata  in  32  A store data.
- a_we  in  4  A byte enables; 0 means read.
- a_rsp_valid  out  1  A response pulse.
- a_rdata  out  32  A load data.
- b_req_valid, b_req_ready, b_addr, b_wdata, b_we, b_rsp_valid, b_rdata: same as the A ports, for B.
- mem_addr  out  32  to memory address pin.
- mem_wdata  out  32  to memory store data.
- mem_we  out  4  to memory byte enables.
- mem_rdata  in  32  load data from memory, valid one cycle after issue.
- starve_cnt  out  CNT_W  current starvation count, for debug.

Behaviour:
- Reset (rst high at posedge):
  - starve_cnt=0, a_rsp_valid=b_rsp_valid=0, a_rdata=b_rdata=0, pending-response register cleared.
  - While rst is high: a_req_ready=b_req_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: an accepted request whose response is due the next cycle is dropped (no rsp pulse). A write already issued to memory is not undone.
- Arbitration (combinational, each cycle, rst low):
  - winner=B if b_req_valid and (!a_req_valid or starve_cnt==STARVE_LIMIT).
  - Otherwise winner=A if a_req_valid.
  - Otherwise no winner.
- Only the winner's ready is 1. A requester is accepted when valid&&ready.
- mem_addr/mem_wdata/mem_we come from the winner. With no winner, mem_we=0 and addr/wdata hold 0.
- Issue state machine:
  - States IDLE and RESP.
  - An accept in either state moves to or stays in RESP, recording owner (A/B) and is_write=(we!=0).
  - RESP with no new accept returns to IDLE.
  - Back-to-back accepts are allowed every cycle (fully pipelined, 1 outstanding per cycle).
- Response, one cycle after accept:
  - The owner's rsp_valid=1 for exactly one cycle.
  - rdata=mem_rdata for reads and 32'h0 for writes (write ack).
  - The non-owner's rsp_valid=0 and its rdata holds its previous value.
- Starvation counter, updated at posedge:
  - A accepted while b_req_valid: starve_cnt+1, saturating at STARVE_LIMIT.
  - B accepted, or b_req_valid low: starve_cnt=0.
  - Otherwise: hold.
- Simultaneous valid, starve_cnt<STARVE_LIMIT: A wins.
- Simultaneous valid, starve_cnt==STARVE_LIMIT: B wins, and A sees ready=0 for that cycle.
- Requesters must hold addr/wdata/we stable while valid && !ready. The arbiter does not buffer unaccepted requests.
- Byte enables are passed through unmodified. No alignment checking. Address bits above the memory depth are passed through; the memory truncates them.

Test Plan:
- Reset: rst=1 for 2 cycles with a_req_valid=1 -> a_req_ready=0, mem_we=0, starve_cnt=0, no rsp pulses. Deassert rst -> A accepted on the first cycle.
- A write then read: A we=4'hF addr=0x10 wdata=0xDEADBEEF. Next cycle A read addr=0x10 -> a_rsp_valid pulse with a_rdata=0 (write ack), then pulse with a_rdata=0xDEADBEEF.
- Priority: a_req_valid=b_req_valid=1 continuously, STARVE_LIMIT=4 -> grant sequence A,A,A,A,B,A,A,A,A,B. starve_cnt reads 0,1,2,3,4,0.
- B alone: b_req_valid=1 read addr=0x20 holding 0x12345678, a idle -> b_req_ready=1 same cycle; b_rsp_valid next cycle with b_rdata=0x12345678; a_rsp_valid stays 0.
- Byte write: B we=4'b0010 wdata=0x0000AB00 to addr=0x30 holding 0x11223344 -> subsequent read returns 0x1122AB44.
- Reset mid-response: accept an A read, assert rst on the next posedge -> a_rsp_valid never pulses; after release, starve_cnt=0.
